// File: rtl/demux_deserializer_32.sv
// 1-to-32 serial demultiplexer/deserializer with valid/ready word output.
// Define DESER_MSB_FIRST_EN to place the first bit of a word in output_lines[31].
module demux_deserializer_32 #(
    parameter int WIDTH    = 32,
    parameter int SEL_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                in_valid,
    input  logic                in_start,
    output logic                in_ready,
    output logic [WIDTH-1:0]    output_lines,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SEL_BITS-1:0] selector_bits
);

    typedef enum logic {
        FILL,
        FULL
    } stateT;

    localparam logic [SEL_BITS-1:0] LAST_POS = SEL_BITS'(WIDTH - 1);

`ifdef DESER_MSB_FIRST_EN
    localparam logic [SEL_BITS-1:0] START_IDX = LAST_POS;
`else
    localparam logic [SEL_BITS-1:0] START_IDX = '0;
`endif

    stateT               state;
    stateT               stateNext;
    logic [WIDTH-1:0]    assembly;
    logic [WIDTH-1:0]    assemblyNext;
    logic [SEL_BITS-1:0] selNext;
    logic [SEL_BITS-1:0] writeIdx;
    logic                accept;
    logic                loadOut;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign accept    = in_valid & in_ready;

    // The counter always runs 0..31; only the physical bit it targets flips.
`ifdef DESER_MSB_FIRST_EN
    assign writeIdx = LAST_POS - selector_bits;
`else
    assign writeIdx = selector_bits;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= stateNext;
        end
    end

    // A start marker always wins over word completion, so a start at
    // position 31 re-aligns the frame instead of emitting a word.
    always_comb begin
        stateNext    = state;
        assemblyNext = assembly;
        selNext      = selector_bits;
        loadOut      = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (in_start) begin
                        assemblyNext            = '0;
                        assemblyNext[START_IDX] = serial_in;
                        selNext                 = SEL_BITS'(1);
                    end else begin
                        assemblyNext[writeIdx] = serial_in;
                        selNext                = selector_bits + SEL_BITS'(1);
                        if (selector_bits == LAST_POS) begin
                            loadOut   = 1'b1;
                            stateNext = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    stateNext = FILL;
                end
            end
            default: stateNext = FILL;
        endcase
    end

    // The output word lives in its own register so the assembly register is
    // free to be overwritten as soon as the word has been handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            assembly      <= '0;
            selector_bits <= '0;
            output_lines  <= '0;
        end else begin
            assembly      <= assemblyNext;
            selector_bits <= selNext;
            if (loadOut) begin
                output_lines <= assemblyNext;
            end
        end
    end

endmodule

// File: tb/tb_demux_deserializer_32.sv
// Randomized and directed bench for demux_deserializer_32 against a bit-position model.
// Honors DESER_MSB_FIRST_EN the same way as the design.
module tb_demux_deserializer_32;

    logic        clk;
    logic        rst;
    logic        serial_in;
    logic        in_valid;
    logic        in_start;
    logic        in_ready;
    logic [31:0] output_lines;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  selector_bits;

    int checks = 0;
    int errors = 0;

    int          modelPos;
    logic [31:0] modelWord;
    logic [31:0] modelOut;
    bit          modelFull;

    demux_deserializer_32 dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .in_valid      (in_valid),
        .in_start      (in_start),
        .in_ready      (in_ready),
        .output_lines  (output_lines),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .selector_bits (selector_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int physIdx(input int pos);
`ifdef DESER_MSB_FIRST_EN
        return 31 - pos;
`else
        return pos;
`endif
    endfunction

    task automatic modelReset();
        modelPos  = 0;
        modelWord = 32'h0;
        modelOut  = 32'h0;
        modelFull = 0;
    endtask

    task automatic checkAll();
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, modelFull});
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !modelFull});
        checkOutput("selector_bits", {27'b0, selector_bits}, modelPos);
        checkOutput("output_lines", output_lines, modelOut);
    endtask

    // One clock: drive at negedge, advance the model at posedge, check just after.
    task automatic applyStimulus(input bit v, input bit s, input bit b, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_start  = s;
        serial_in = b;
        out_ready = r;
        @(posedge clk);
        if (!modelFull) begin
            if (v) begin
                if (s) begin
                    modelWord = 32'(b) << physIdx(0);
                    modelPos  = 1;
                end else begin
                    modelWord = (modelWord & ~(32'h1 << physIdx(modelPos))) | (32'(b) << physIdx(modelPos));
                    if (modelPos == 31) begin
                        modelOut  = modelWord;
                        modelFull = 1;
                        modelPos  = 0;
                    end else begin
                        modelPos = modelPos + 1;
                    end
                end
            end
        end else if (r) begin
            modelFull = 0;
        end
        #1;
        checkAll();
    endtask

    // Sends a word in wire order so that it lands unchanged in output_lines.
    task automatic sendWord(input logic [31:0] word, input bit gapped);
        for (int i = 0; i < 32; i++) begin
            if (gapped) applyStimulus(0, 0, 1'($urandom), 0);
            applyStimulus(1, 0, word[physIdx(i)], 0);
        end
    endtask

    task automatic drainWord();
        applyStimulus(0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        serial_in = 0;
        in_valid = 0;
        in_start = 0;
        out_ready = 0;
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        sendWord(32'hA5A5_F00F, 0);
        checkOutput("word_a5a5f00f", output_lines, 32'hA5A5_F00F);
        checkOutput("full_sel_zero", {27'b0, selector_bits}, 32'h0);

        for (int i = 0; i < 5; i++) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 0);
        checkOutput("held_word", output_lines, 32'hA5A5_F00F);
        drainWord();
        checkOutput("drained_ready", {31'b0, in_ready}, 32'h1);

        sendWord(32'h0000_0001, 1);
        checkOutput("word_gapped", output_lines, 32'h0000_0001);
        drainWord();

        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 1'($urandom), 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("start_sel", {27'b0, selector_bits}, 32'h1);
        for (int i = 0; i < 31; i++) applyStimulus(1, 0, 1, 0);
        checkOutput("word_after_start", output_lines, 32'hFFFF_FFFF);
        drainWord();

        for (int i = 0; i < 31; i++) applyStimulus(1, 0, 1'($urandom), 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("start_at_31_no_emit", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1'($urandom), 0);
        checkOutput("pre_reset_sel", {27'b0, selector_bits}, 32'd17);

        @(negedge clk);
        in_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        sendWord(32'h1234_5678, 0);
        checkOutput("word_after_reset", output_lines, 32'h1234_5678);
        drainWord();

        sendWord(32'h8000_0000, 0);
        checkOutput("word_80000000", output_lines, 32'h8000_0000);
        drainWord();

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
                          1'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
